mux_rr_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/rr_pick3.sv | 45 ++++
 rtl/mux_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin operand mux arbiter.
//   ST_EMPTY / ST_FULL : occupancy of the one-entry output register
//   SEL_OPT1..3        : mux select codes for requesters 0..2
//   NUM_REQ            : number of requesters sharing the mux
package mux_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [1:0] SEL_OPT1 = 2'd0;
  localparam logic [1:0] SEL_OPT2 = 2'd1;
  localparam logic [1:0] SEL_OPT3 = 2'd2;

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker.
// Searches req starting at last+1 (mod 3) and returns the first set bit.
// Ports:
//   req        in  [2:0] request bits
//   last       in  [1:0] index granted most recently (3 treated like 2)
//   gnt_onehot out [2:0] one-hot winner, zero when no request
//   gnt_idx    out [1:0] winner index, SEL_OPT1 when no request
//   any        out       at least one request is present
module rr_pick3
  import mux_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt_onehot,
  output logic [1:0] gnt_idx,
  output logic       any
);

  always_comb begin
    gnt_onehot = 3'b000;
    gnt_idx    = SEL_OPT1;
    any        = |req;

    case (last)
      2'd0: begin
        if      (req[1]) gnt_idx = SEL_OPT2;
        else if (req[2]) gnt_idx = SEL_OPT3;
        else if (req[0]) gnt_idx = SEL_OPT1;
      end
      2'd1: begin
        if      (req[2]) gnt_idx = SEL_OPT3;
        else if (req[0]) gnt_idx = SEL_OPT1;
        else if (req[1]) gnt_idx = SEL_OPT2;
      end
      default: begin
        if      (req[0]) gnt_idx = SEL_OPT1;
        else if (req[1]) gnt_idx = SEL_OPT2;
        else if (req[2]) gnt_idx = SEL_OPT3;
      end
    endcase

    if (any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing the 32-bit three-input result mux between
// three valid/ready requesters. The winning operand is captured into a
// one-entry output register presented downstream with valid/ready.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid[2:0]          per-requester operand valid
//   req_data0..2            requester operands (mux options 1..3)
//   req_ready[2:0]          one-hot accept of the granted requester
//   selection[1:0]          mux select of current grant (holds when idle)
//   out_valid/out_data      registered operand towards the datapath
//   out_src[1:0]            requester index that produced out_data
//   out_ready               downstream accept
// Optional: define MUX_ARB_GRANT_CNT_EN to add grant_cnt0..2, wrapping
// per-requester grant counters of CNT_W bits.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic [2:0]        req_ready,
  output logic [1:0]        selection,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  input  logic              out_ready
`ifdef MUX_ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  grant_cnt2
`endif
);

  state_e            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;

  logic [2:0]        pick_onehot;
  logic [1:0]        pick_idx;
  logic              pick_any;
  logic              load_en;
  logic              grant;
  logic [DATA_W-1:0] mux_data;

  rr_pick3 u_pick (
    .req        (req_valid),
    .last       (last_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // The register can take a new operand when empty or when it is being
  // popped this cycle; reset blocks any accept so nothing is lost.
  assign load_en   = (state_q == ST_EMPTY) || out_ready;
  assign grant     = load_en && pick_any && !reset;
  assign req_ready = grant ? pick_onehot : 3'b000;
  assign selection = grant ? pick_idx : sel_q;

  always_comb begin
    mux_data = req_data0;
    case (pick_idx)
      SEL_OPT2: mux_data = req_data1;
      SEL_OPT3: mux_data = req_data2;
      default:  mux_data = req_data0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    data_d  = data_q;
    src_d   = src_q;
    if (grant) begin
      state_d = ST_FULL;
      last_d  = pick_idx;
      sel_d   = pick_idx;
      data_d  = mux_data;
      src_d   = pick_idx;
    end else if (out_ready) begin
      // Pop without refill; data and source keep their stale values.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      last_q  <= SEL_OPT3;
      sel_q   <= SEL_OPT1;
      data_q  <= '0;
      src_q   <= SEL_OPT1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef MUX_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant && (pick_idx == 2'(i))) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];
  assign grant_cnt2 = cnt_q[2];
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

`ifdef MUX_ARB_GRANT_CNT_EN
  localparam int TB_CNT_W = 2;
`else
  localparam int TB_CNT_W = 16;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = 3'b000;
  logic [31:0] req_data0 = '0, req_data1 = '0, req_data2 = '0;
  logic [2:0]  req_ready;
  logic [1:0]  selection;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready = 1'b0;
`ifdef MUX_ARB_GRANT_CNT_EN
  logic [TB_CNT_W-1:0] grant_cnt0, grant_cnt1, grant_cnt2;
`endif

  mux_rr_arbiter #(.DATA_W(32), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_ready (req_ready),
    .selection (selection),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .grant_cnt2 (grant_cnt2)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: occupancy, last winner, held select, grant tallies,
  // and a queue of {src, data} that the output register must present.
  logic [33:0] exp_q[$];
  bit          m_full;
  int          m_last;
  int          m_sel;
  int          m_cnt[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expectations come from the round-robin rule:
  // search last+1, last+2, last+3 (mod 3) when the register can load.
  task automatic cycle(input logic [2:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic rdy);
    bit         le;
    int         g;
    int         cand;
    logic [2:0] exp_rdy;
    logic [31:0] gd;
    @(negedge clk);
    req_valid = v;
    req_data0 = a;
    req_data1 = b;
    req_data2 = c;
    out_ready = rdy;
    #1;
    chk("out_valid", out_valid, m_full);
    le = !m_full || rdy;
    g = -1;
    if (le) begin
      for (int k = 1; k <= 3; k++) begin
        cand = (m_last + k) % 3;
        if (g < 0 && v[cand]) g = cand;
      end
    end
    exp_rdy = 3'b000;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      m_sel = g;
    end
    chk("req_ready", req_ready, exp_rdy);
    chk("selection", selection, m_sel);
    if (g >= 0) begin
      gd = (g == 0) ? a : (g == 1) ? b : c;
      exp_q.push_back({2'(g), gd});
      m_last = g;
      m_full = 1'b1;
      m_cnt[g] = m_cnt[g] + 1;
    end else if (rdy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 3'b111;
    out_ready = 1'b1;
    #1;
    chk("req_ready_in_reset", req_ready, 3'b000);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 3'b000;
    out_ready = 1'b0;
    #1;
    exp_q.delete();
    m_full = 1'b0;
    m_last = 2;
    m_sel  = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_src", out_src, 2'd0);
    chk("rst_selection", selection, 2'd0);
  endtask

  // Monitor: while the register is occupied its contents must equal the
  // oldest expected entry; the entry retires when downstream accepts.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: out_valid=1 data=%0h expected no operand", out_data);
        end else begin
          chk("out_data", out_data, {32'd0, exp_q[0][31:0]});
          chk("out_src", out_src, exp_q[0][33:32]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();

`ifdef MUX_ARB_GRANT_CNT_EN
    repeat (5) cycle(3'b001, 32'd7, 32'd0, 32'd0, 1'b1);
    cycle(3'b000, 0, 0, 0, 1'b1);
    #1;
    chk("grant_cnt0_wrap", grant_cnt0, 2'd1);
    chk("grant_cnt0_model", grant_cnt0, m_cnt[0] % 4);
    chk("grant_cnt1", grant_cnt1, 2'd0);
    chk("grant_cnt2", grant_cnt2, 2'd0);
    do_reset();
`endif

    // All three valid: rotation 0,1,2,0 at one operand per cycle.
    repeat (4) cycle(3'b111, 32'd30, 32'd40, 32'd50, 1'b1);
    cycle(3'b000, 0, 0, 0, 1'b1);

    // Backpressure: one accept then hold with req_ready low.
    repeat (4) cycle(3'b010, 32'd0, 32'd40, 32'd0, 1'b0);
    cycle(3'b000, 0, 0, 0, 1'b1);

    // Pop and push in the same cycle.
    cycle(3'b001, 32'd30, 32'd0, 32'd0, 1'b1);
    cycle(3'b100, 32'd0, 32'd0, 32'd50, 1'b1);
    cycle(3'b000, 0, 0, 0, 1'b0);
    #1;
    chk("pop_push_data", out_data, 32'd50);
    chk("pop_push_valid", out_valid, 1'b1);
    cycle(3'b000, 0, 0, 0, 1'b1);

    // Last grant 0 with 0 and 2 requesting: 2 wins, then 0.
    cycle(3'b001, 32'd11, 32'd0, 32'd0, 1'b1);
    repeat (2) cycle(3'b101, 32'd12, 32'd0, 32'd13, 1'b1);
    cycle(3'b000, 0, 0, 0, 1'b1);

    // Reset while full and stalled discards the operand.
    cycle(3'b100, 32'd0, 32'd0, 32'd99, 1'b0);
    cycle(3'b100, 32'd0, 32'd0, 32'd98, 1'b0);
    do_reset();
    cycle(3'b111, 32'd1, 32'd2, 32'd3, 1'b1);
    cycle(3'b000, 0, 0, 0, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 3) != 0));
    end
    repeat (3) cycle(3'b000, 0, 0, 0, 1'b1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
